// File: rtl/time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : time_counter
//  Description : 24-hour clock with a one-second prescaler, a three-state
//                mode FSM for setting hours and minutes, and a registered
//                display multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_counter #(
    parameter int CLK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [1:0] disp_sel,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [5:0] hour,
    output logic [5:0] val,
    output logic [1:0] mode,
    output logic       sec_tick
);

    // Prescaler width is sized to hold CLK_DIV-1.
    localparam int             PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    hour_q, hour_d;
    logic [5:0]    val_q, val_d;
    logic          tick_q, tick_d;

    // Next-state logic: mode changes take priority over increments and ticks.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        tick_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (mode_btn) begin
                    state_d = SET_HOUR;
                    sec_d   = 6'd0;
                    presc_d = '0;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (sec_q == 6'd59) begin
                        sec_d = 6'd0;
                        if (min_q == 6'd59) begin
                            min_d  = 6'd0;
                            hour_d = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            SET_HOUR: begin
                presc_d = '0;
                if (mode_btn) begin
                    state_d = SET_MIN;
                end else if (inc_btn) begin
                    hour_d = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
                end
            end
            SET_MIN: begin
                presc_d = '0;
                if (mode_btn) begin
                    state_d = RUN;
                end else if (inc_btn) begin
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end
            end
            default: begin
                state_d = RUN;
                presc_d = '0;
            end
        endcase
    end

    // Display mux samples the current field values, adding one cycle of latency.
    always_comb begin
        val_d = 6'd0;
        case (disp_sel)
            2'b00:   val_d = sec_q;
            2'b01:   val_d = min_q;
            2'b10:   val_d = hour_q;
            default: val_d = 6'd0;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            presc_q <= '0;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hour_q  <= 6'd0;
            val_q   <= 6'd0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            val_q   <= val_d;
            tick_q  <= tick_d;
        end
    end

    assign sec      = sec_q;
    assign min      = min_q;
    assign hour     = hour_q;
    assign val      = val_q;
    assign mode     = state_q;
    assign sec_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_counter
//  Description : Directed self-checking bench for time_counter (CLK_DIV=4)
//                with a queue of expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_counter;

    localparam int CLK_DIV = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       mode_btn = 1'b0;
    logic       inc_btn  = 1'b0;
    logic [1:0] disp_sel = 2'b00;
    logic [5:0] sec, min, hour, val;
    logic [1:0] mode;
    logic       sec_tick;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];

    time_counter #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .disp_sel (disp_sel),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .val      (val),
        .mode     (mode),
        .sec_tick (sec_tick)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) e = 32'hDEAD_BEEF;
        else                   e = exp_q.pop_front();
        n_total++;
        assert (obs === e) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic m, input logic i);
        mode_btn = m;
        inc_btn  = i;
        step();
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        push(0); push(0); push(0); push(0); push(0); push(0);
        check({tag, "_sec"},  32'(sec));
        check({tag, "_min"},  32'(min));
        check({tag, "_hour"}, 32'(hour));
        check({tag, "_val"},  32'(val));
        check({tag, "_mode"}, 32'(mode));
        check({tag, "_tick"}, 32'(sec_tick));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b0;
        #1;
        check_all_zero("rst_async");
        step();
        step();
        rst = 1'b1;

        // Twelve cycles of RUN: ticks at cycles 4, 8, 12
        for (int k = 1; k <= 12; k++) begin
            push((k % 4) == 0);
            step();
            check("run_tick", 32'(sec_tick));
        end
        push(3);
        check("run_sec3", 32'(sec));

        // Enter SET_HOUR, 25 increments wrap to 1
        push(1); push(0);
        pulse(1'b1, 1'b0);
        check("set_hour_mode", 32'(mode));
        check("set_hour_sec_clr", 32'(sec));
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            pulse(1'b0, 1'b1);
            if (sec_tick !== 1'b0) bad++;
        end
        push(0); push(1); push(0);
        check("set_hour_no_tick", 32'(bad));
        check("set_hour_wrap", 32'(hour));
        check("set_hour_min", 32'(min));

        // Hour to 23, then SET_MIN wrap from 59 without carry
        repeat (22) pulse(1'b0, 1'b1);
        push(23);
        check("hour_23", 32'(hour));
        push(2);
        pulse(1'b1, 1'b0);
        check("set_min_mode", 32'(mode));
        repeat (59) pulse(1'b0, 1'b1);
        push(59);
        check("min_59", 32'(min));
        push(0); push(23);
        pulse(1'b0, 1'b1);
        check("min_wrap", 32'(min));
        check("min_wrap_hour", 32'(hour));

        // Simultaneous mode and inc: mode wins
        push(0); push(0);
        pulse(1'b1, 1'b1);
        check("both_mode", 32'(mode));
        check("both_min", 32'(min));

        // Preload 23:59:00, then 59 ticks to 23:59:59 (inc ignored in RUN)
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        repeat (59) pulse(1'b0, 1'b1);
        push(0);
        pulse(1'b1, 1'b0);
        check("back_to_run", 32'(mode));
        bad = 0;
        for (int k = 1; k <= 59 * CLK_DIV; k++) begin
            if (k == 100) inc_btn = 1'b1;
            step();
            inc_btn = 1'b0;
            if (sec_tick !== ((k % CLK_DIV) == 0)) bad++;
        end
        push(0); push(23); push(59); push(59);
        check("preload_tick_pos", 32'(bad));
        check("preload_hour", 32'(hour));
        check("preload_min", 32'(min));
        check("preload_sec", 32'(sec));
        repeat (CLK_DIV - 1) step();
        push(0); push(59);
        check("pre_roll_tick", 32'(sec_tick));
        check("pre_roll_sec", 32'(sec));
        step();
        push(1); push(0); push(0); push(0);
        check("roll_tick", 32'(sec_tick));
        check("roll_hour", 32'(hour));
        check("roll_min", 32'(min));
        check("roll_sec", 32'(sec));

        // Set 5:17, run 42 seconds
        pulse(1'b1, 1'b0);
        repeat (5) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        repeat (17) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        repeat (42 * CLK_DIV) step();
        push(5); push(17); push(42);
        check("t_hour", 32'(hour));
        check("t_min", 32'(min));
        check("t_sec", 32'(sec));

        // Display select sweep
        disp_sel = 2'b00; push(42); step(); check("val_sec", 32'(val));
        disp_sel = 2'b01; push(17); step(); check("val_min", 32'(val));
        disp_sel = 2'b10; push(5);  step(); check("val_hour", 32'(val));
        disp_sel = 2'b11; push(0);  step(); check("val_zero", 32'(val));

        // Asynchronous reset mid-cycle in SET_HOUR
        push(1); push(5);
        pulse(1'b1, 1'b0);
        check("pre_rst_mode", 32'(mode));
        check("pre_rst_hour", 32'(hour));
        #2 rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 1; k <= CLK_DIV; k++) begin
            push(k == CLK_DIV);
            step();
            check("post_rst_tick", 32'(sec_tick));
        end
        push(1);
        check("post_rst_sec", 32'(sec));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000000, meaning clk cycles per one-second tick (legal range 2 or more).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port mode_btn, input, 1 bit: single-cycle pulse, already debounced, that advances the mode.
REQ-005 SHALL have port inc_btn, input, 1 bit: single-cycle pulse, already debounced, that increments the field being set.
REQ-006 SHALL have port disp_sel, input, 2 bits: display source select.
REQ-007 SHALL have port sec, output, 6 bits: seconds, range 0..59.
REQ-008 SHALL have port min, output, 6 bits: minutes, range 0..59.
REQ-009 SHALL have port hour, output, 6 bits: hours, range 0..23.
REQ-010 SHALL have port val, output, 6 bits: registered display value for the downstream LED driver.
REQ-011 SHALL have port mode, output, 2 bits: current state; 00 RUN, 01 SET_HOUR, 10 SET_MIN.
REQ-012 SHALL have port sec_tick, output, 1 bit: one-cycle pulse on each seconds increment.

Function
REQ-013 SHALL keep a prescaler that counts 0..CLK_DIV-1 and wraps to 0; a tick occurs in the cycle where the count equals CLK_DIV-1.
REQ-014 SHALL only run the prescaler in RUN; in SET_HOUR and SET_MIN the prescaler SHALL be held at 0.
REQ-015 On a tick in RUN, SHALL increment sec; sec at 59 SHALL wrap to 0 and carry into min.
REQ-016 min at 59 with a carry SHALL wrap to 0 and carry into hour; hour at 23 with a carry SHALL wrap to 0, so 23:59:59 becomes 00:00:00 in one tick.
REQ-017 SHALL assert sec_tick for exactly the cycle in which sec updates; sec_tick SHALL be 0 outside RUN.
REQ-018 SHALL follow the mode FSM: a mode_btn pulse moves RUN to SET_HOUR, SET_HOUR to SET_MIN, and SET_MIN to RUN; with no pulse the state holds.
REQ-019 On the transition from RUN to SET_HOUR, SHALL clear sec and the prescaler to 0.
REQ-020 In SET_HOUR, an inc_btn pulse SHALL increment hour, with 23 wrapping to 0 and no carry; min and sec are unchanged.
REQ-021 In SET_MIN, an inc_btn pulse SHALL increment min, with 59 wrapping to 0 and no carry into hour; hour and sec are unchanged.
REQ-022 In RUN, inc_btn SHALL be ignored.
REQ-023 If mode_btn and inc_btn pulse in the same cycle, the mode change SHALL win and inc_btn SHALL be ignored.
REQ-024 On the transition from SET_MIN to RUN, the prescaler SHALL start from 0, so the first tick occurs CLK_DIV cycles after the transition.
REQ-025 SHALL register val from disp_sel with one cycle of latency relative to the field values:
- 00: sec
- 01: min
- 10: hour
- 11: 6'b0
REQ-026 Every counter SHALL be wide enough for its range, and the prescaler SHALL hold CLK_DIV-1 without overflow.
REQ-027 Out-of-range values SHALL be unreachable: sec and min never exceed 59, hour never exceeds 23.

Reset
REQ-028 While rst=0, SHALL force asynchronously, without waiting for a clock edge:
- sec, min, hour, val = 0
- mode = RUN
- sec_tick = 0
- prescaler = 0
REQ-029 Reset asserted mid-operation, including during a set mode or in a tick cycle, SHALL abandon that operation with no partial update.
REQ-030 After rst deasserts, counting SHALL start from prescaler 0 on the first rising clk edge.

Verification (CLK_DIV=4)
REQ-031 Reset release, then 12 cycles in RUN -> sec_tick pulses at cycles 4, 8 and 12; sec reads 3.
REQ-032 Preload 23:59:59 via set modes plus ticks, then one tick -> hour=0, min=0, sec=0 in the same cycle.
REQ-033 One mode_btn, then 25 inc_btn pulses -> mode=01, hour=1, sec=0, sec_tick stays 0.
REQ-034 In SET_MIN with min=59, one inc_btn -> min=0 and hour unchanged; then mode_btn and inc_btn in the same cycle -> mode=00 and min stays 0.
REQ-035 disp_sel stepped through 00, 01, 10, 11 with time 5:17:42 -> val = 42, 17, 5, 0, each one cycle after the select.
REQ-036 rst pulled low asynchronously mid-cycle in SET_HOUR -> all outputs are 0 and mode=00 before the next edge.
